cache_beat_dispatcher: RTL

Downstream consumer of the memory controller's cache port 02. It pops CACHE_WIDTH-bit cache words through the read_req02/empty02 interface. Each word is serialized into BEATS narrow beats on a valid/ready stream toward the PE array. A one-word prefetch slot hides the one-cycle cache read latency, so steady-state beat output has no bubbles.

---
 rtl/cache_beat_dispatcher.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cache_beat_dispatcher.sv
// Pops cache words from port 02 and serializes each into BEATS narrow beats
// on a valid/ready stream, with a one-word prefetch slot to avoid bubbles.
module cache_beat_dispatcher #(
  parameter int CACHE_WIDTH = 162,
  parameter int BEAT_WIDTH  = 27,
  parameter int BEATS       = 6,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   cfg_words,
  output logic                   busy,
  output logic                   done,
  output logic                   read_req02,
  input  logic                   empty02,
  input  logic [CACHE_WIDTH-1:0] cache02_out,
  output logic [BEAT_WIDTH-1:0]  beat_data,
  output logic                   beat_valid,
  input  logic                   beat_ready,
  output logic                   beat_last,
  output logic                   frame_last,
  output logic [1:0]             dbg_state
);

  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  // Stream handshake: a beat transfers on a cycle where beat_valid, beat_ready
  // and clk_en are all high; beat_valid never drops before that transfer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   words_tot_q, words_tot_d;
  logic [CNT_WIDTH-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_WIDTH-1:0]   sent_cnt_q, sent_cnt_d;
  logic                   rd_pending_q, rd_pending_d;
  logic                   nxt_vld_q, nxt_vld_d;
  logic [CACHE_WIDTH-1:0] nxt_word_q, nxt_word_d;
  logic                   cur_vld_q, cur_vld_d;
  logic [CACHE_WIDTH-1:0] cur_word_q, cur_word_d;
  logic [IDX_W-1:0]       beat_idx_q, beat_idx_d;

  logic fire;
  logic last_fire;
  logic load;

  assign busy       = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign dbg_state  = state_q;
  assign beat_valid = cur_vld_q;
  assign beat_data  = cur_word_q[beat_idx_q*BEAT_WIDTH +: BEAT_WIDTH];
  assign beat_last  = cur_vld_q && (beat_idx_q == LAST_IDX);
  assign frame_last = beat_last && (sent_cnt_q == (words_tot_q - CNT_WIDTH'(1)));

  assign read_req02 = (state_q == ST_RUN) && clk_en && !empty02 && !nxt_vld_q &&
                      !rd_pending_q && (req_cnt_q < words_tot_q);
  assign fire      = cur_vld_q && beat_ready && clk_en;
  assign last_fire = fire && beat_last;
  // Uses the registered nxt_vld, so a capture never races a move.
  assign load      = (!cur_vld_q || last_fire) && nxt_vld_q;

  always_comb begin
    state_d      = state_q;
    words_tot_d  = words_tot_q;
    req_cnt_d    = req_cnt_q;
    sent_cnt_d   = sent_cnt_q;
    rd_pending_d = rd_pending_q;
    nxt_vld_d    = nxt_vld_q;
    nxt_word_d   = nxt_word_q;
    cur_vld_d    = cur_vld_q;
    cur_word_d   = cur_word_q;
    beat_idx_d   = beat_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          words_tot_d = cfg_words;
          req_cnt_d   = '0;
          sent_cnt_d  = '0;
          state_d     = (cfg_words == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (fire && frame_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (read_req02) begin
      req_cnt_d    = req_cnt_q + CNT_WIDTH'(1);
      rd_pending_d = 1'b1;
    end else if (rd_pending_q) begin
      rd_pending_d = 1'b0;
    end

    if (load) nxt_vld_d = 1'b0;
    if (rd_pending_q) begin
      nxt_word_d = cache02_out;
      nxt_vld_d  = 1'b1;
    end

    if (load) begin
      cur_word_d = nxt_word_q;
      cur_vld_d  = 1'b1;
      beat_idx_d = '0;
    end else if (fire) begin
      if (beat_last) begin
        cur_vld_d  = 1'b0;
        beat_idx_d = '0;
      end else begin
        beat_idx_d = beat_idx_q + IDX_W'(1);
      end
    end

    if (last_fire) sent_cnt_d = sent_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      words_tot_q  <= '0;
      req_cnt_q    <= '0;
      sent_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      nxt_vld_q    <= 1'b0;
      nxt_word_q   <= '0;
      cur_vld_q    <= 1'b0;
      cur_word_q   <= '0;
      beat_idx_q   <= '0;
    end else if (clk_en) begin
      state_q      <= state_d;
      words_tot_q  <= words_tot_d;
      req_cnt_q    <= req_cnt_d;
      sent_cnt_q   <= sent_cnt_d;
      rd_pending_q <= rd_pending_d;
      nxt_vld_q    <= nxt_vld_d;
      nxt_word_q   <= nxt_word_d;
      cur_vld_q    <= cur_vld_d;
      cur_word_q   <= cur_word_d;
      beat_idx_q   <= beat_idx_d;
    end
  end

endmodule
